fifo_rd_ctrl: RTL and testbench



---
 rtl/fifo_pkg.sv | 24 ++
 rtl/ptr_sync.sv | 34 +++
 rtl/fifo_rd_ctrl.sv | 114 +++++++++++
 tb/tb_fifo_rd_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: geometry, pointer type and Gray conversions
// used by both the read-side and write-side controllers.
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_WIDTH = 5;
  localparam int unsigned DEPTH           = 1 << FIFO_ADDR_WIDTH;
  localparam int unsigned PTR_WIDTH       = FIFO_ADDR_WIDTH + 1;

  typedef logic [PTR_WIDTH-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    bin[PTR_WIDTH-1] = gray[PTR_WIDTH-1];
    for (int i = int'(PTR_WIDTH) - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchronizer for a Gray pointer crossing into the local clock.
// Also exposes the input of the last stage so consumers can register from it.
module ptr_sync
  import fifo_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WIDTH       = PTR_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_ptr,
  output logic [WIDTH-1:0] o_ptr,
  output logic [WIDTH-1:0] o_ptr_next
);

  logic [WIDTH-1:0] r_stage [SYNC_STAGES];

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_ptr;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_ptr      = r_stage[SYNC_STAGES-1];
  assign o_ptr_next = r_stage[SYNC_STAGES-2];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO: read pointer, synchronized write
// pointer, empty/almost-empty/underflow flags, level, count and read data.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = FIFO_ADDR_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  rclk,
  input  logic                  sw_rst,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] aempty_value,
  input  logic [ADDR_WIDTH:0]   wptr_gray,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  rempty,
  output logic                  rd_almost_empty,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   fifo_read_count,
  output logic [ADDR_WIDTH:0]   rd_level
);

  // Pointer arithmetic is shared with the package helpers, so geometry must match.
  if (ADDR_WIDTH != FIFO_ADDR_WIDTH || SYNC_STAGES < 2) begin : g_param_check
    $error("fifo_rd_ctrl: ADDR_WIDTH must match fifo_pkg and SYNC_STAGES must be >= 2");
  end

  ptr_t                  r_rptr_bin;
  ptr_t                  r_rptr_gray;
  ptr_t                  r_count;
  ptr_t                  r_level;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rdata_valid;
  logic                  r_rempty;
  logic                  r_aempty;
  logic                  r_underflow;

  ptr_t                  w_wq_gray;
  ptr_t                  w_wq_gray_next;
  ptr_t                  w_wq_bin_next;
  ptr_t                  w_rptr_bin_next;
  ptr_t                  w_rptr_gray_next;
  ptr_t                  w_level_next;
  logic                  w_accept;

  ptr_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (PTR_WIDTH)
  ) u_wptr_sync (
    .i_clk      (rclk),
    .i_clr      (sw_rst),
    .i_ptr      (wptr_gray),
    .o_ptr      (w_wq_gray),
    .o_ptr_next (w_wq_gray_next)
  );

  // Next-state pointers; flags are registered from these so they never lag a read.
  always_comb begin
    w_accept         = read_enable & ~r_rempty;
    w_rptr_bin_next  = r_rptr_bin + PTR_WIDTH'(w_accept);
    w_rptr_gray_next = bin2gray(w_rptr_bin_next);
    w_wq_bin_next    = gray2bin(w_wq_gray_next);
    w_level_next     = w_wq_bin_next - w_rptr_bin_next;
  end

  always_ff @(posedge rclk) begin
    if (sw_rst) begin
      r_rptr_bin    <= '0;
      r_rptr_gray   <= '0;
      r_count       <= '0;
      r_level       <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_rempty      <= 1'b1;
      r_aempty      <= 1'b1;
      r_underflow   <= 1'b0;
    end else begin
      r_rptr_bin    <= w_rptr_bin_next;
      r_rptr_gray   <= w_rptr_gray_next;
      r_count       <= r_count + PTR_WIDTH'(w_accept);
      r_level       <= w_level_next;
      r_rdata_valid <= w_accept;
      r_rempty      <= (w_rptr_gray_next == w_wq_gray_next);
      r_aempty      <= (w_level_next <= {1'b0, aempty_value});
      r_underflow   <= read_enable & r_rempty;
      if (w_accept) begin
        r_rdata <= mem_rdata;
      end
    end
  end

  // Registered level/empty must always agree with the current pointer pair.
  always @(posedge rclk) begin
    if (!sw_rst) begin
      assert ((r_level == ptr_t'(gray2bin(w_wq_gray) - r_rptr_bin)) &&
              (r_rempty == (r_level == '0)));
    end
  end

  assign raddr           = r_rptr_bin[ADDR_WIDTH-1:0];
  assign rptr_gray       = r_rptr_gray;
  assign rdata           = r_rdata;
  assign rdata_valid     = r_rdata_valid;
  assign rempty          = r_rempty;
  assign rd_almost_empty = r_aempty;
  assign underflow       = r_underflow;
  assign fifo_read_count = r_count;
  assign rd_level        = r_level;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: bench-side memory and pointer model,
// read data scoreboard, directed scenarios for flags, wrap, full and reset.
module tb_fifo_rd_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          rclk;
  logic          sw_rst;
  logic          read_enable;
  logic [AW-1:0] aempty_value;
  logic [AW:0]   wptr_gray;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr_gray;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic          rempty;
  logic          rd_almost_empty;
  logic          underflow;
  logic [AW:0]   fifo_read_count;
  logic [AW:0]   rd_level;

  logic [DW-1:0] tb_mem [32];
  logic [DW-1:0] sb_q [$];
  logic [DW-1:0] mon_exp;
  int            errors = 0;
  int            checks = 0;
  int            m_wptr;
  int            m_rptr;

  fifo_rd_ctrl #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .SYNC_STAGES (2)
  ) dut (
    .rclk            (rclk),
    .sw_rst          (sw_rst),
    .read_enable     (read_enable),
    .aempty_value    (aempty_value),
    .wptr_gray       (wptr_gray),
    .mem_rdata       (mem_rdata),
    .raddr           (raddr),
    .rptr_gray       (rptr_gray),
    .rdata           (rdata),
    .rdata_valid     (rdata_valid),
    .rempty          (rempty),
    .rd_almost_empty (rd_almost_empty),
    .underflow       (underflow),
    .fifo_read_count (fifo_read_count),
    .rd_level        (rd_level)
  );

  // Asynchronous-read memory model
  assign mem_rdata = tb_mem[raddr];

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic logic [AW:0] to_gray(input int n);
    logic [AW:0] b;
    b = (AW+1)'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic write_n(input int n);
    for (int i = 0; i < n; i++) begin
      tb_mem[5'(m_wptr % 32)] = $urandom;
      m_wptr++;
    end
    wptr_gray = to_gray(m_wptr);
  endtask

  // Called on a cycle the bench knows the read will be accepted
  task automatic read_push();
    sb_q.push_back(tb_mem[5'(m_rptr % 32)]);
    m_rptr++;
  endtask

  // Scoreboard: every rdata_valid must match the oldest expected word
  always @(posedge rclk) begin
    #2;
    if (rdata_valid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_valid: rdata=%h with no read outstanding", rdata);
      end else begin
        mon_exp = sb_q.pop_front();
        if (rdata !== mon_exp) begin
          errors++;
          $display("FAIL sb_rdata: got=%h exp=%h", rdata, mon_exp);
        end
      end
    end
  end

  task automatic test_reset();
    sw_rst = 1'b1; read_enable = 1'b0; wptr_gray = '0; aempty_value = '0;
    m_wptr = 0; m_rptr = 0;
    tick(); tick();
    sw_rst = 1'b0;
    checks++;
    if ({rdata_valid, rempty, rd_almost_empty, underflow} !== 4'b0110) begin
      errors++;
      $display("FAIL reset_flags: got={v,e,ae,uf}=%b exp=0110",
               {rdata_valid, rempty, rd_almost_empty, underflow});
    end
    checks++;
    if ({raddr, rptr_gray, fifo_read_count, rd_level} !== '0) begin
      errors++;
      $display("FAIL reset_ptrs: raddr=%0d rptr_gray=%b count=%0d level=%0d exp all 0",
               raddr, rptr_gray, fifo_read_count, rd_level);
    end
    checks++;
    if (rdata !== '0) begin
      errors++;
      $display("FAIL reset_rdata: got=%h exp=0", rdata);
    end
  endtask

  task automatic test_underflow();
    read_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({underflow, rempty, raddr} !== {1'b1, 1'b1, 5'd0}) begin
        errors++;
        $display("FAIL underflow_pulse[%0d]: uf=%b empty=%b raddr=%0d exp 1 1 0",
                 i, underflow, rempty, raddr);
      end
    end
    read_enable = 1'b0;
    tick();
    checks++;
    if ({underflow, fifo_read_count, rd_level} !== {1'b0, 6'd0, 6'd0}) begin
      errors++;
      $display("FAIL underflow_end: uf=%b count=%0d level=%0d exp 0 0 0",
               underflow, fifo_read_count, rd_level);
    end
  endtask

  task automatic test_basic();
    aempty_value = 5'd1;
    write_n(3);
    tick();
    checks++;
    if (rempty !== 1'b1) begin
      errors++;
      $display("FAIL basic_sync_latency: rempty=%b exp 1 one edge after wptr", rempty);
    end
    tick();
    checks++;
    if ({rempty, rd_level, rd_almost_empty} !== {1'b0, 6'd3, 1'b0}) begin
      errors++;
      $display("FAIL basic_level3: empty=%b level=%0d ae=%b exp 0 3 0",
               rempty, rd_level, rd_almost_empty);
    end
    read_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (raddr !== 5'(i)) begin
        errors++;
        $display("FAIL basic_raddr[%0d]: got=%0d exp=%0d", i, raddr, i);
      end
      read_push();
      tick();
    end
    read_enable = 1'b0;
    checks++;
    if ({rempty, rd_level, fifo_read_count, rd_almost_empty} !== {1'b1, 6'd0, 6'd3, 1'b1}) begin
      errors++;
      $display("FAIL basic_drained: empty=%b level=%0d count=%0d ae=%b exp 1 0 3 1",
               rempty, rd_level, fifo_read_count, rd_almost_empty);
    end
    checks++;
    if (rptr_gray !== to_gray(3)) begin
      errors++;
      $display("FAIL basic_rptr_gray: got=%b exp=%b", rptr_gray, to_gray(3));
    end
  endtask

  task automatic test_aempty();
    aempty_value = 5'd4;
    write_n(5);
    tick(); tick();
    checks++;
    if ({rd_level, rd_almost_empty} !== {6'd5, 1'b0}) begin
      errors++;
      $display("FAIL aempty_above: level=%0d ae=%b exp 5 0", rd_level, rd_almost_empty);
    end
    read_enable = 1'b1;
    read_push();
    tick();
    read_enable = 1'b0;
    checks++;
    if ({rd_level, rd_almost_empty} !== {6'd4, 1'b1}) begin
      errors++;
      $display("FAIL aempty_at_threshold: level=%0d ae=%b exp 4 1", rd_level, rd_almost_empty);
    end
    read_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      read_push();
      tick();
    end
    read_enable = 1'b0;
    checks++;
    if ({rempty, rd_level} !== {1'b1, 6'd0}) begin
      errors++;
      $display("FAIL aempty_drain: empty=%b level=%0d exp 1 0", rempty, rd_level);
    end
  endtask

  task automatic test_wrap();
    logic [AW:0] prev_gray;
    for (int b = 0; b < 4; b++) begin
      write_n(20);
      tick(); tick();
      checks++;
      if (rd_level !== 6'd20) begin
        errors++;
        $display("FAIL wrap_level[%0d]: got=%0d exp=20", b, rd_level);
      end
      read_enable = 1'b1;
      for (int i = 0; i < 20; i++) begin
        checks++;
        if (raddr !== 5'(m_rptr % 32)) begin
          errors++;
          $display("FAIL wrap_raddr: got=%0d exp=%0d", raddr, m_rptr % 32);
        end
        prev_gray = rptr_gray;
        read_push();
        tick();
        checks++;
        if (rptr_gray !== to_gray(m_rptr) || $countones(prev_gray ^ rptr_gray) != 1
            || rdata_valid !== 1'b1) begin
          errors++;
          $display("FAIL wrap_gray: got=%b prev=%b exp=%b valid=%b",
                   rptr_gray, prev_gray, to_gray(m_rptr), rdata_valid);
        end
      end
      read_enable = 1'b0;
      checks++;
      if ({rempty, rd_level, fifo_read_count} !== {1'b1, 6'd0, 6'(m_rptr % 64)}) begin
        errors++;
        $display("FAIL wrap_drained[%0d]: empty=%b level=%0d count=%0d exp 1 0 %0d",
                 b, rempty, rd_level, fifo_read_count, m_rptr % 64);
      end
    end
  endtask

  task automatic test_full();
    write_n(32);
    tick(); tick();
    checks++;
    if ({rd_level, rempty, rd_almost_empty} !== {6'd32, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL full_level: level=%0d empty=%b ae=%b exp 32 0 0",
               rd_level, rempty, rd_almost_empty);
    end
    // Pointer-only advance: the slot it names still holds an unread word
    m_wptr++;
    wptr_gray = to_gray(m_wptr);
    tick();
    checks++;
    if (rd_level !== 6'd32) begin
      errors++;
      $display("FAIL full_pre_read: level=%0d exp 32", rd_level);
    end
    read_enable = 1'b1;
    read_push();
    tick();
    read_enable = 1'b0;
    checks++;
    if ({rd_level, rempty} !== {6'd32, 1'b0}) begin
      errors++;
      $display("FAIL full_read_and_write: level=%0d empty=%b exp 32 0", rd_level, rempty);
    end
    tick();
    checks++;
    if (rd_level !== 6'd32) begin
      errors++;
      $display("FAIL full_hold: level=%0d exp 32", rd_level);
    end
    read_enable = 1'b1;
    for (int i = 0; i < 32; i++) begin
      read_push();
      tick();
    end
    read_enable = 1'b0;
    checks++;
    if ({rempty, rd_level} !== {1'b1, 6'd0}) begin
      errors++;
      $display("FAIL full_drain: empty=%b level=%0d exp 1 0", rempty, rd_level);
    end
  endtask

  task automatic test_reset_mid();
    write_n(10);
    tick(); tick();
    checks++;
    if (rd_level !== 6'd10) begin
      errors++;
      $display("FAIL rstmid_level: got=%0d exp=10", rd_level);
    end
    wptr_gray = '0;
    sw_rst = 1'b1;
    read_enable = 1'b1;
    tick();
    sw_rst = 1'b0;
    read_enable = 1'b0;
    m_wptr = 0;
    m_rptr = 0;
    checks++;
    if ({rdata_valid, rempty, rd_almost_empty, underflow} !== 4'b0110) begin
      errors++;
      $display("FAIL rstmid_flags: got={v,e,ae,uf}=%b exp=0110",
               {rdata_valid, rempty, rd_almost_empty, underflow});
    end
    checks++;
    if ({raddr, rptr_gray, fifo_read_count, rd_level} !== '0 || rdata !== '0) begin
      errors++;
      $display("FAIL rstmid_state: raddr=%0d gray=%b count=%0d level=%0d rdata=%h exp all 0",
               raddr, rptr_gray, fifo_read_count, rd_level, rdata);
    end
    tick(); tick();
    checks++;
    if ({rempty, rd_level} !== {1'b1, 6'd0}) begin
      errors++;
      $display("FAIL rstmid_after: empty=%b level=%0d exp 1 0", rempty, rd_level);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) tb_mem[i] = '0;
    sw_rst = 1'b1;
    read_enable = 1'b0;
    aempty_value = '0;
    wptr_gray = '0;
    test_reset();
    test_underflow();
    test_basic();
    test_aempty();
    test_wrap();
    test_full();
    test_reset_mid();
    tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_outstanding: got=%0d words never returned exp=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
